ps2_key_event_rx: RTL and testbench

PS2_KEY_EVENT_RX -- requirements
Module: ps2_key_event_rx

---
 rtl/ps2_key_event_rx.sv | 168 ++++++++++++++++
 tb/tb_ps2_key_event_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 keyboard receiver that decodes E0/F0 prefixes into
// {ext, break, code} key events and buffers them in a first-word-fall-through FIFO.
module ps2_key_event_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          evt_ready,
    input  logic                          clr_err,
    output logic                          evt_valid,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    key_cnt,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
    logic                   r_clk_prev;
    logic [3:0]             r_bit_cnt;
    logic [9:0]             r_shift;
    logic [TW-1:0]          r_to_cnt;
    logic                   r_byte_vld;
    logic [7:0]             r_byte;
    state_t                 r_state, w_state_nxt;
    logic [9:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wp, r_rp;
    logic [CW-1:0]          r_count;
    logic [7:0]             r_key_cnt;
    logic                   r_par_err, r_frm_err, r_ovf;

    logic        w_clk, w_data, w_fall, w_last, w_fr_bad, w_par_bad, w_good;
    logic        w_timeout, w_abort, w_push, w_pop, w_full, w_wr, w_ext, w_brk;
    logic [10:0] w_frame;
    logic [9:0]  w_head;

    assign w_clk  = r_clk_sync[SYNC_STAGES-1];
    assign w_data = r_dat_sync[SYNC_STAGES-1];
    assign w_fall = r_clk_prev & ~w_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev <= w_clk;
        end
    end

    // Bits arrive LSB first, so after ten edges r_shift[0] holds the start bit.
    assign w_frame   = {w_data, r_shift};
    assign w_last    = w_fall && (r_bit_cnt == 4'd10);
    assign w_fr_bad  = w_last && (w_frame[0] || !w_frame[10]);
    assign w_par_bad = w_last && !w_fr_bad && !(^w_frame[9:1]);
    assign w_good    = w_last && !w_fr_bad && (^w_frame[9:1]);
    assign w_timeout = (r_bit_cnt != 4'd0) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_abort   = w_fr_bad || w_par_bad || w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= 4'd0;
            r_shift    <= '0;
            r_to_cnt   <= '0;
            r_byte_vld <= 1'b0;
            r_byte     <= 8'd0;
        end else begin
            r_byte_vld <= w_good;
            if (w_good)
                r_byte <= w_frame[8:1];
            if (w_fall)
                r_shift <= {w_data, r_shift[9:1]};
            if (w_timeout)
                r_bit_cnt <= 4'd0;
            else if (w_fall)
                r_bit_cnt <= w_last ? 4'd0 : r_bit_cnt + 4'd1;
            if (w_fall || w_timeout || r_bit_cnt == 4'd0)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign w_ext = (r_state == S_EXT) || (r_state == S_EXT_BRK);
    assign w_brk = (r_state == S_BRK) || (r_state == S_EXT_BRK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        if (r_byte_vld) begin
            if (r_byte == 8'hE0)
                w_state_nxt = (r_state == S_IDLE) ? S_EXT : (r_state == S_BRK) ? S_EXT_BRK : r_state;
            else if (r_byte == 8'hF0)
                w_state_nxt = (r_state == S_IDLE) ? S_BRK : (r_state == S_EXT) ? S_EXT_BRK : r_state;
            else begin
                w_push      = 1'b1;
                w_state_nxt = S_IDLE;
            end
        end
        if (w_abort)
            w_state_nxt = S_IDLE;
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign evt_valid = (r_count != '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = evt_valid && evt_ready;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_head    = r_mem[r_rp];
    assign evt_code  = evt_valid ? w_head[7:0] : 8'd0;
    assign evt_break = evt_valid && w_head[8];
    assign evt_ext   = evt_valid && w_head[9];

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wp] <= {w_ext, w_brk, r_byte};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_key_cnt <= 8'd0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + AW'(1);
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            r_count <= r_count + CW'(w_wr) - CW'(w_pop);
            if (w_wr && !w_brk)
                r_key_cnt <= r_key_cnt + 8'd1;
            r_par_err <= (r_par_err && !clr_err) || w_par_bad;
            r_frm_err <= (r_frm_err && !clr_err) || w_fr_bad || w_timeout;
            r_ovf     <= (r_ovf && !clr_err) || (w_push && w_full && !w_pop);
        end
    end

    assign fifo_count = r_count;
    assign key_cnt    = r_key_cnt;
    assign parity_err = r_par_err;
    assign frame_err  = r_frm_err;
    assign overflow   = r_ovf;
endmodule

// File: tb/tb_ps2_key_event_rx.sv
// tb_ps2_key_event_rx: directed PS/2 frames from a vector table plus hand-written
// sequences for latency, framing/timeout errors, overflow and mid-frame reset.
module tb_ps2_key_event_rx;
    localparam int H     = 8;
    localparam int TO    = 100;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic       evt_ready = 1'b0, clr_err = 1'b0;
    logic       evt_valid, evt_ext, evt_break, parity_err, frame_err, overflow;
    logic [7:0] evt_code, key_cnt;
    logic [$clog2(DEPTH):0] fifo_count;
    int n_chk = 0, n_fail = 0;

    ps2_key_event_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt_ready(evt_ready), .clr_err(clr_err), .evt_valid(evt_valid),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
        .fifo_count(fifo_count), .key_cnt(key_cnt), .parity_err(parity_err),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       bad;
        logic       lat;
        logic       ev;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] kc;
        logic       perr;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic bad);
        return {1'b1, (~^d) ^ bad, d, 1'b0};
    endfunction

    task automatic send_raw(input logic [10:0] f, input int n, input bit lat);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            for (int c = 1; c <= H; c++) begin
                @(negedge clk);
                if (lat && i == 10 && c == SYNC + 1) chk("latency_early", evt_valid, 0);
                if (lat && i == 10 && c == SYNC + 2) chk("latency_on_time", evt_valid, 1);
            end
            ps2_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic pop();
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           d     bad  lat  ev   code   ext  brk  kc  perr
        tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[1]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[3]  = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 8'd1, 1'b0};
        tbl[4]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[5]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b1, 8'd1, 1'b0};
        tbl[6]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 1'b0};
        tbl[7]  = '{8'h6B, 1'b0, 1'b0, 1'b1, 8'h6B, 1'b1, 1'b0, 8'd2, 1'b0};
        tbl[8]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd2, 1'b0};
        tbl[9]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd2, 1'b0};
        tbl[10] = '{8'h74, 1'b0, 1'b0, 1'b1, 8'h74, 1'b1, 1'b1, 8'd2, 1'b0};
        tbl[11] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd2, 1'b0};
        tbl[12] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd2, 1'b0};
        tbl[13] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'd3, 1'b0};
        tbl[14] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd3, 1'b1};
        tbl[15] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd3, 1'b1};
        tbl[16] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd3, 1'b1};
        tbl[17] = '{8'h33, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'd4, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_valid", evt_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_keycnt", key_cnt, 0);
        chk("rst_flags", {parity_err, frame_err, overflow}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 18; r++) begin
            send_raw(mk(tbl[r].d, tbl[r].bad), 11, tbl[r].lat);
            chk($sformatf("row%0d_valid", r), evt_valid, tbl[r].ev);
            chk($sformatf("row%0d_code", r), evt_code, tbl[r].code);
            chk($sformatf("row%0d_ext", r), evt_ext, tbl[r].ext);
            chk($sformatf("row%0d_brk", r), evt_break, tbl[r].brk);
            chk($sformatf("row%0d_count", r), fifo_count, tbl[r].ev);
            chk($sformatf("row%0d_keycnt", r), key_cnt, tbl[r].kc);
            chk($sformatf("row%0d_perr", r), parity_err, tbl[r].perr);
            if (evt_valid) pop();
        end

        clr();
        chk("perr_cleared", parity_err, 0);

        send_raw({1'b0, ~^8'h1C, 8'h1C, 1'b0}, 11, 1'b0);
        chk("stop_bad_ferr", frame_err, 1);
        chk("stop_bad_noevt", evt_valid, 0);
        chk("stop_bad_perr", parity_err, 0);
        clr();
        chk("ferr_cleared", frame_err, 0);
        send_raw({1'b1, ~^8'h1C, 8'h1C, 1'b1}, 11, 1'b0);
        chk("start_bad_ferr", frame_err, 1);
        chk("start_bad_noevt", evt_valid, 0);
        clr();

        send_raw(mk(8'h29, 1'b0), 5, 1'b0);
        chk("partial_no_ferr", frame_err, 0);
        repeat (TO + 1) @(negedge clk);
        chk("timeout_ferr", frame_err, 1);
        chk("timeout_bitcnt", dut.r_bit_cnt, 0);
        clr();
        send_raw(mk(8'h29, 1'b0), 11, 1'b0);
        chk("after_to_valid", evt_valid, 1);
        chk("after_to_code", evt_code, 8'h29);
        chk("after_to_keycnt", key_cnt, 5);
        chk("after_to_ferr", frame_err, 0);
        pop();

        begin
            logic [7:0] ov[5];
            ov = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
            for (int k = 0; k < 5; k++) send_raw(mk(ov[k], 1'b0), 11, 1'b0);
            chk("ovf_count", fifo_count, DEPTH);
            chk("ovf_flag", overflow, 1);
            chk("ovf_keycnt", key_cnt, 9);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("ovf_read%0d", k), evt_code, ov[k]);
                pop();
            end
            chk("ovf_drained_count", fifo_count, 0);
            chk("ovf_drained_valid", evt_valid, 0);
        end

        send_raw(mk(8'h1C, 1'b0), 6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", evt_valid, 0);
        chk("midrst_keycnt", key_cnt, 0);
        chk("midrst_flags", {parity_err, frame_err, overflow}, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_bitcnt", dut.r_bit_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_raw(mk(8'h1C, 1'b0), 11, 1'b0);
        chk("postrst_valid", evt_valid, 1);
        chk("postrst_code", evt_code, 8'h1C);
        chk("postrst_keycnt", key_cnt, 1);
        chk("postrst_ferr", frame_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
